alu_74181_rr_sched: RTL and testbench
=====================================

Name: alu_74181_rr_sched

Overview:
Round-robin scheduler that shares one 4-bit alu_74181_logic instance among NUM_REQ requesters. Each requester offers operands a, b and function select s with a valid/ready handshake. The block grants one requester, registers its operands and registers the ALU result. It then returns the result with the winner's ID over a valid/ready response channel. It sits between the tile's per-lane request logic and the shared logic ALU.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index (derived localparam, not overridable)
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  requester i presents an operation
req_ready  output  NUM_REQ  one-hot grant/accept strobe
req_a  input  4*NUM_REQ  operand A, requester i at [4i+3:4i]
req_b  input  4*NUM_REQ  operand B, same packing
req_s  input  4*NUM_REQ  function select, same packing
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_f  output  4  ALU result
rsp_id  output  ID_W  index of requester that issued the operation
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed responses, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, operand/s/id registers=0, rsp_f=0, rsp_id=0, rsp_valid=0, busy=0, op_count=0, req_ready=0.
- FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - If any req_valid is set, winner = first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in this cycle only. It is a function of req_valid, state and rr_ptr.
  - On the clock edge: latch a/b/s/id of the winner, set rr_ptr=(winner+1) mod NUM_REQ, go to EXEC.
  - If no request is valid: stay in IDLE, all req_ready=0.
- EXEC: one cycle. The ALU is driven from the latched a/b/s. Its output is registered into rsp_f, rsp_id is driven from the latched id, rsp_valid is set, state goes to RESP.
- RESP:
  - rsp_valid=1. rsp_f and rsp_id stay stable until the handshake.
  - On rsp_valid&&rsp_ready: clear rsp_valid, op_count+=1 (wraps 2^CNT_W-1→0), go to IDLE.
  - No requests are accepted in EXEC or RESP; all req_ready=0.
- Latency:
  - Accept edge → rsp_valid high after 2 edges.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with rsp_ready=1).
- Simultaneous requests: only one grant per accept. Losers hold valid and operands stable. Starvation-free: any held request is granted within NUM_REQ accepts.
- Pointer wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
- A requester dropping valid before it is granted has no effect and is legal.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is produced, and all reset values apply immediately (async). The requester must re-issue.
- Function encoding is the 4-bit s of the existing logic ALU. The block passes s through unchanged and performs no decode.

Decomposition:
- Package alu_74181_pkg:
  - func_type enum FUNC_00..FUNC_15 (logic [3:0]), shared with the ALU
  - sched_state_t enum {IDLE, EXEC, RESP}
  - localparam ALU_W=4
- Sub-module rr_arbiter: parameters NUM_REQ; inputs req, ptr; outputs grant one-hot, grant_idx, any. Purely combinational.
- Instantiate alu_74181_logic unchanged as the datapath.

Test Plan:
- Single request: requester 0 valid with a=4'hA, b=4'h5, s=4'd6 (XOR). Expect req_ready[0] pulse in the same cycle, rsp_valid 2 edges later with rsp_f=4'hF, rsp_id=0, op_count=1.
- Contention: all 4 requesters valid continuously from reset, rsp_ready=1. Expect grant order 0,1,2,3,0 at 3-cycle spacing; each rsp_id matches and each rsp_f matches that requester's operands.
- Backpressure: requester 2 with a=4'h3, b=4'hC, s=4'd14 (OR), rsp_ready=0 for 5 cycles. Expect rsp_valid held, rsp_f=4'hF stable, busy=1, no req_ready. Raising rsp_ready completes the response and returns to IDLE the next cycle.
- Pointer wrap/fairness: grant requester 3 first, then assert requesters 0 and 3 together. Expect 0 granted before 3.
- Reset mid-op: assert rst during EXEC, then during RESP. Expect rsp_valid=0, op_count=0 and state IDLE immediately, and no late response after rst deasserts.
- Function sweep: requester 1, a=4'b1100, b=4'b1010, s=0..15. Expect f = 3,1,2,0,7,5,6,4,B,9,A,8,F,D,E,C (hex).

Source files
------------

// File: rtl/alu_74181_pkg.sv
// Shared types for the 74181-style logic ALU and its round-robin scheduler.
package alu_74181_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [3:0] {
    FUNC_00, FUNC_01, FUNC_02, FUNC_03,
    FUNC_04, FUNC_05, FUNC_06, FUNC_07,
    FUNC_08, FUNC_09, FUNC_10, FUNC_11,
    FUNC_12, FUNC_13, FUNC_14, FUNC_15
  } func_type;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

endpackage

// File: rtl/alu_74181_logic.sv
// 74181 logic-mode datapath (M=1, active-high data): 16 bitwise functions of a and b.
module alu_74181_logic
  import alu_74181_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       s,
  output logic [ALU_W-1:0] f
);

  always_comb begin
    f = '0;
    case (func_type'(s))
      FUNC_00: f = ~a;
      FUNC_01: f = ~(a | b);
      FUNC_02: f = ~a & b;
      FUNC_03: f = '0;
      FUNC_04: f = ~(a & b);
      FUNC_05: f = ~b;
      FUNC_06: f = a ^ b;
      FUNC_07: f = a & ~b;
      FUNC_08: f = ~a | b;
      FUNC_09: f = ~(a ^ b);
      FUNC_10: f = b;
      FUNC_11: f = a & b;
      FUNC_12: f = '1;
      FUNC_13: f = a | ~b;
      FUNC_14: f = a | b;
      FUNC_15: f = a;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_74181_rr_sched.sv
// Shares one logic ALU among NUM_REQ requesters: grant in IDLE, compute in EXEC, hold result in RESP.
module alu_74181_rr_sched
  import alu_74181_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [ALU_W*NUM_REQ-1:0] req_a,
  input  logic [ALU_W*NUM_REQ-1:0] req_b,
  input  logic [ALU_W*NUM_REQ-1:0] req_s,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ALU_W-1:0]         rsp_f,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ALU_W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ALU_W-1:0] rsp_f_q, rsp_f_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;
  logic [ALU_W-1:0]   alu_f;

  logic [ALU_W-1:0] a_arr [NUM_REQ];
  logic [ALU_W-1:0] b_arr [NUM_REQ];
  logic [ALU_W-1:0] s_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*ALU_W +: ALU_W];
    assign b_arr[g] = req_b[g*ALU_W +: ALU_W];
    assign s_arr[g] = req_s[g*ALU_W +: ALU_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  alu_74181_logic u_alu (
    .a (a_q),
    .b (b_q),
    .s (s_q),
    .f (alu_f)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    id_d        = id_q;
    rsp_f_d     = rsp_f_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = grant;
          a_d       = a_arr[grant_idx];
          b_d       = b_arr[grant_idx];
          s_d       = s_arr[grant_idx];
          id_d      = grant_idx;
          rr_ptr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : ID_W'(grant_idx + ID_W'(1));
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_f_d     = alu_f;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      id_q        <= '0;
      rsp_f_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      id_q        <= id_d;
      rsp_f_q     <= rsp_f_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_74181_rr_sched.sv
// Self-checking bench for alu_74181_rr_sched: directed scenarios plus a randomized run against a reference model.
module tb_alu_74181_rr_sched;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [4*N-1:0] req_a, req_b, req_s;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [3:0]   rsp_f;
  logic [1:0]   rsp_id;
  logic         busy;
  logic [7:0]   op_count;

  int checks = 0;
  int failures = 0;
  int cnt_model = 0;

  logic [N-1:0] op_v;
  logic [3:0]   op_a [N];
  logic [3:0]   op_b [N];
  logic [3:0]   op_s [N];

  logic [3:0] exp_tab [16] = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
                               4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC};

  alu_74181_rr_sched #(.NUM_REQ(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_s     (req_s),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Datasheet gate equations of the 74181 in logic mode, independent of the function table.
  function automatic logic [3:0] mdl_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [3:0] x, y;
    x = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
    y = ~((a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}));
    return ~(x ^ y);
  endfunction

  task automatic apply();
    req_valid = op_v;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = op_a[i];
      req_b[4*i +: 4] = op_b[i];
      req_s[4*i +: 4] = op_s[i];
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    op_v[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
    op_s[i] = s;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    op_v = '0;
    apply();
    tick();
    tick();
    rst = 1'b0;
    #1;
    cnt_model = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    op_v = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_s[i] = '0; end
    apply();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_f !== 4'h0 || rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp got=%h/%0d exp=0/0", rsp_f, rsp_id); end
    rst = 1'b0;
    #1;
    cnt_model = 0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(0, 4'hA, 4'h5, 4'd6);
    apply();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    op_v = '0;
    apply();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
      failures++; $display("FAIL single_exec got=v%b b%b r%b exp=v0 b1 r0000", rsp_valid, busy, req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_f !== 4'hF || rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp got=%h/%0d exp=f/0", rsp_f, rsp_id); end
    tick();
    cnt_model++;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=v%b b%b exp=v0 b0", rsp_valid, busy); end
    checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_contention();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom), 4'($urandom));
    for (int g = 0; g < 5; g++) begin
      int w;
      logic [3:0] ef;
      w = g % N;
      apply();
      checks++; if (req_ready !== 4'(1 << w)) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%b", g, req_ready, 4'(1 << w)); end
      ef = mdl_f(op_a[w], op_b[w], op_s[w]);
      tick();
      set_op(w, 4'($urandom), 4'($urandom), 4'($urandom));
      apply();
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL contention_exec_ready%0d got=%b exp=0000", g, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_f !== ef || rsp_id !== 2'(w)) begin
        failures++; $display("FAIL contention_rsp%0d got=v%b f%h id%0d exp=v1 f%h id%0d", g, rsp_valid, rsp_f, rsp_id, ef, w); end
      tick();
      cnt_model++;
    end
    op_v = '0;
    apply();
    checks++; if (op_count !== 8'(cnt_model)) begin failures++; $display("FAIL contention_op_count got=%0d exp=%0d", op_count, cnt_model); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    op_v = '0;
    set_op(2, 4'h3, 4'hC, 4'd14);
    apply();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick();
    op_v = '0;
    apply();
    tick();
    set_op(0, 4'($urandom), 4'($urandom), 4'($urandom));
    apply();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_f !== 4'hF || rsp_id !== 2'd2 || busy !== 1'b1 || req_ready !== 4'b0) begin
        failures++; $display("FAIL bp_hold%0d got=v%b f%h id%0d b%b r%b exp=v1 ff id2 b1 r0000", c, rsp_valid, rsp_f, rsp_id, busy, req_ready); end
      tick();
    end
    op_v = '0;
    rsp_ready = 1'b1;
    apply();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_still_valid got=%b exp=1", rsp_valid); end
    tick();
    cnt_model++;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'(cnt_model)) begin
      failures++; $display("FAIL bp_release got=v%b b%b cnt%0d exp=v0 b0 cnt%0d", rsp_valid, busy, op_count, cnt_model); end
  endtask

  task automatic test_fairness();
    rsp_ready = 1'b1;
    op_v = '0;
    set_op(3, 4'($urandom), 4'($urandom), 4'($urandom));
    apply();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL fair_first3 got=%b exp=1000", req_ready); end
    tick();
    op_v = '0;
    apply();
    tick();
    checks++; if (rsp_id !== 2'd3) begin failures++; $display("FAIL fair_id3 got=%0d exp=3", rsp_id); end
    tick();
    cnt_model++;
    set_op(0, 4'($urandom), 4'($urandom), 4'($urandom));
    set_op(3, 4'($urandom), 4'($urandom), 4'($urandom));
    apply();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL fair_wrap0 got=%b exp=0001", req_ready); end
    tick();
    op_v[0] = 1'b0;
    apply();
    tick();
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL fair_id0 got=%0d exp=0", rsp_id); end
    tick();
    cnt_model++;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL fair_then3 got=%b exp=1000", req_ready); end
    tick();
    op_v = '0;
    apply();
    tick();
    checks++; if (rsp_id !== 2'd3) begin failures++; $display("FAIL fair_id3b got=%0d exp=3", rsp_id); end
    tick();
    cnt_model++;
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b1;
    op_v = '0;
    set_op(1, 4'h9, 4'h6, 4'd6);
    apply();
    tick();
    op_v = '0;
    apply();
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
      failures++; $display("FAIL rst_exec got=v%b b%b cnt%0d exp=v0 b0 cnt0", rsp_valid, busy, op_count); end
    cnt_model = 0;
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_exec_late%0d got=v%b b%b exp=v0 b0", c, rsp_valid, busy); end
      tick();
    end
    set_op(1, 4'h1, 4'h2, 4'd14);
    apply();
    tick();
    op_v = '0;
    apply();
    tick();
    tick();
    cnt_model++;
    set_op(1, 4'h5, 4'h5, 4'd9);
    apply();
    tick();
    op_v = '0;
    apply();
    tick();
    checks++; if (rsp_valid !== 1'b1 || op_count !== 8'd1) begin failures++; $display("FAIL rst_pre_resp got=v%b cnt%0d exp=v1 cnt1", rsp_valid, op_count); end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0 || rsp_f !== 4'h0) begin
      failures++; $display("FAIL rst_resp got=v%b b%b cnt%0d f%h exp=v0 b0 cnt0 f0", rsp_valid, busy, op_count, rsp_f); end
    cnt_model = 0;
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_resp_late%0d got=v%b b%b exp=v0 b0", c, rsp_valid, busy); end
      tick();
    end
  endtask

  task automatic test_func_sweep();
    rsp_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      op_v = '0;
      set_op(1, 4'b1100, 4'b1010, 4'(s));
      apply();
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL sweep_grant%0d got=%b exp=0010", s, req_ready); end
      tick();
      op_v = '0;
      apply();
      tick();
      checks++; if (rsp_f !== exp_tab[s] || rsp_id !== 2'd1) begin
        failures++; $display("FAIL sweep_f%0d got=%h id%0d exp=%h id1", s, rsp_f, rsp_id, exp_tab[s]); end
      tick();
      cnt_model++;
    end
    checks++; if (op_count !== 8'(cnt_model)) begin failures++; $display("FAIL sweep_op_count got=%0d exp=%0d", op_count, cnt_model); end
  endtask

  task automatic test_random();
    int ptr, age, eid, w;
    bit pend;
    logic [3:0] ef;
    logic [N-1:0] exp_rdy;
    do_reset();
    ptr = 0; pend = 1'b0; age = 0; eid = 0; ef = '0;
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!op_v[i] && $urandom_range(2) == 0) set_op(i, 4'($urandom), 4'($urandom), 4'($urandom));
        else if (op_v[i] && $urandom_range(15) == 0) op_v[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(3) != 0);
      apply();
      w = -1;
      if (!pend)
        for (int k = 0; k < N; k++)
          if (w < 0 && op_v[(ptr + k) % N]) w = (ptr + k) % N;
      exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready c%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== 1'(pend && age >= 2)) begin failures++; $display("FAIL rand_valid c%0d got=%b exp=%b", c, rsp_valid, pend && age >= 2); end
      if (pend && age >= 2) begin
        checks++; if (rsp_f !== ef || rsp_id !== 2'(eid)) begin
          failures++; $display("FAIL rand_rsp c%0d got=%h/%0d exp=%h/%0d", c, rsp_f, rsp_id, ef, eid); end
      end
      checks++; if (busy !== pend) begin failures++; $display("FAIL rand_busy c%0d got=%b exp=%b", c, busy, pend); end
      checks++; if (op_count !== 8'(cnt_model)) begin failures++; $display("FAIL rand_op_count c%0d got=%0d exp=%0d", c, op_count, 8'(cnt_model)); end
      if (w >= 0) begin
        pend = 1'b1; age = 1; eid = w;
        ef = mdl_f(op_a[w], op_b[w], op_s[w]);
        ptr = (w + 1) % N;
        op_v[w] = 1'b0;
      end else if (pend) begin
        if (age >= 2 && rsp_ready) begin pend = 1'b0; cnt_model++; end
        else age++;
      end
      tick();
    end
    op_v = '0;
    apply();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fairness();
    test_reset_midop();
    test_func_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
